exe_mem_elastic_reg: RTL and testbench
======================================

# exe_mem_elastic_reg

Parametrised, elastic EXE→MEM pipeline register for the ARM968E-S core. It carries the execute-stage result bundle (PC, ALU result, Rm value, destination register, memory/writeback enables) into the memory stage. It adds per-stage valid/ready handshaking, a synchronous flush for branch recovery, and an optional skid entry so that in_ready is registered. It replaces the fixed-width, always-advancing EXE stage register wherever the memory stage can stall.

## Interface
Parameters:
- ADDR_W, 32: width of pc, ALU result and Rm value fields.
- DEST_W, 4: width of destination register index.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries and of the current input.
- in_valid  in  1  EXE bundle valid.
- in_ready  out  1  register can accept the bundle this cycle.
- pc_in, alu_res_in, val_rm_in  in  ADDR_W each  EXE payload.
- dest_in  in  DEST_W  destination register.
- mem_w_en_in, mem_r_en_in, wb_en_in  in  1 each  control bits.
- out_valid  out  1  MEM-side bundle valid.
- out_ready  in  1  MEM stage consumes the bundle this cycle.
- pc_out, alu_res_out, val_rm_out  out  ADDR_W each  head payload.
- dest_out  out  DEST_W  head destination.
- mem_w_en_out, mem_r_en_out, wb_en_out  out  1 each  head control bits ANDed with out_valid.
- occupancy  out  2  entries held, 0..2 (0..1 without skid).

## Operation
- Accept: in_valid && in_ready && !flush. Drain: out_valid && out_ready.
- Storage: head entry (drives outputs), plus skid entry when SKID is compiled in.
- Head empty, or draining: an accepted input, or the skid entry if the skid is full, loads into the head. The skid has priority over the input, which can only arrive while the skid is empty.
- Head full and not draining: an accepted input goes to the skid entry.
- Skid full and head drains: the skid moves to the head and the skid is emptied in the same edge.
- Control outputs are gated by out_valid, so a bubble never asserts a memory or writeback enable.
- Payload of an empty entry is don't-care, but RTL holds the last value. There are no X propagations after reset.
- flush: the next edge clears head and skid valid and drops the current input. It overrides accept and drain in the same cycle.
- rst: asynchronously clears all valid bits and zeroes all payload registers.

## Timing
- Latency: one cycle from accept to out_valid, when the head was empty or draining.
- Reset values: out_valid=0, all payload outputs 0, all control outputs 0, occupancy=0. in_ready=0 while rst is asserted, and 1 from the first cycle after release.
- With skid: in_ready = !skid_valid, taken directly from a flop with no combinational path from out_ready. Full throughput of 1 bundle/cycle is maintained under continuous out_ready.
- Without skid: in_ready = !out_valid || out_ready, which is combinational. Full throughput is still maintained.
- Boundaries:
  - Accept while full is impossible (in_ready=0).
  - Drain and accept in the same cycle with occupancy 1 leaves occupancy 1 and loads the new data into the head.
  - With occupancy 2 and out_ready=1, occupancy goes to 1 and in_ready rises next cycle.
  - flush with occupancy 2 gives occupancy 0 next cycle.
  - rst mid-transfer: the entry is lost and outputs go to 0 immediately, without waiting for clk.

## Configuration
- Macro: EXE_MEM_REG_SKID_EN.
- Defined: 2-entry storage (head plus skid), registered in_ready, occupancy range 0..2.
- Undefined: the skid entry is not instantiated, in_ready is combinational, occupancy range is 0..1, and occupancy[1] is tied 0.

## Test plan
- Reset, then a single bundle with pc_in=0x10, alu_res_in=0xDEADBEEF, dest_in=4'h3, wb_en_in=1, and out_ready=1. Required: the next cycle shows out_valid=1, alu_res_out=0xDEADBEEF, dest_out=3, wb_en_out=1. The cycle after shows out_valid=0 and wb_en_out=0.
- Stream of 8 bundles (alu_res 1..8) with out_ready=1 throughout. Required: 8 consecutive out_valid cycles, values 1..8 in order, and in_ready never 0.
- Skid build: out_ready=0 and send bundles A=0xA, B=0xB, C=0xC. Required: occupancy=2 and in_ready=0 after B, with C held upstream. Then set out_ready=1. Required: the outputs are A, B, C on consecutive cycles.
- Flush with occupancy 2 and in_valid=1. Required: the next cycle shows out_valid=0, occupancy=0, mem_w_en_out=0, and the input is not emitted later.
- Async reset pulse between clock edges while out_valid=1. Required: out_valid and all outputs go to 0 before the next edge, and in_ready=1 one cycle after release.
- Build without EXE_MEM_REG_SKID_EN, with out_ready=0 and one bundle held. Required: in_ready=0. Then raise out_ready. Required: in_ready=1 in the same cycle, and a new bundle is accepted in that cycle.

Source files
------------

// File: rtl/exe_mem_elastic_reg.sv
// exe_mem_elastic_reg: elastic EXE->MEM pipeline register with valid/ready
// handshaking, synchronous flush and an optional skid entry.
//
// Build option: define EXE_MEM_REG_SKID_EN to add the skid entry, which makes
// in_ready come straight from a flop (occupancy 0..2). Without it the block
// holds one entry and in_ready is combinational from out_ready (occupancy 0..1).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               kill all held entries and the current input next edge
//   in_valid/in_ready   upstream handshake (EXE side)
//   pc_in, alu_res_in, val_rm_in, dest_in, mem_w_en_in, mem_r_en_in, wb_en_in
//                       EXE payload
//   out_valid/out_ready downstream handshake (MEM side)
//   pc_out, alu_res_out, val_rm_out, dest_out
//                       head payload
//   mem_w_en_out, mem_r_en_out, wb_en_out
//                       head control bits, forced low when out_valid is low
//   occupancy           number of held entries
module exe_mem_elastic_reg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] alu_res_in,
  input  logic [ADDR_W-1:0] val_rm_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              mem_w_en_in,
  input  logic              mem_r_en_in,
  input  logic              wb_en_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] alu_res_out,
  output logic [ADDR_W-1:0] val_rm_out,
  output logic [DEST_W-1:0] dest_out,
  output logic              mem_w_en_out,
  output logic              mem_r_en_out,
  output logic              wb_en_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] alu_res;
    logic [ADDR_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
    logic              mem_w_en;
    logic              mem_r_en;
    logic              wb_en;
  } entry_t;

  entry_t in_e;
  entry_t head_q, head_d;
  logic   head_v_q, head_v_d;
  logic   accept, drain;

  // Pack the incoming bundle
  assign in_e.pc       = pc_in;
  assign in_e.alu_res  = alu_res_in;
  assign in_e.val_rm   = val_rm_in;
  assign in_e.dest     = dest_in;
  assign in_e.mem_w_en = mem_w_en_in;
  assign in_e.mem_r_en = mem_r_en_in;
  assign in_e.wb_en    = wb_en_in;

  assign accept = in_valid && in_ready && !flush;
  assign drain  = head_v_q && out_ready;

`ifdef EXE_MEM_REG_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_v_q, skid_v_d;
  logic   ready_q;

  // Registered ready; it is the inverse of the next skid state, so an
  // accept can only ever land in an empty skid.
  assign in_ready  = ready_q;
  assign occupancy = 2'(head_v_q) + 2'(skid_v_q);

  // Next-state: skid refills the head ahead of any new input
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!head_v_q || drain) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        head_v_d = accept;
        if (accept) head_d = in_e;
      end
    end else if (accept) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      ready_q  <= !skid_v_d;
    end
  end
`else
  // Single entry: ready whenever the head is empty or leaving this cycle
  assign in_ready  = !rst && (!head_v_q || out_ready);
  assign occupancy = {1'b0, head_v_q};

  // Next-state for the head entry
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    if (flush) begin
      head_v_d = 1'b0;
    end else if (!head_v_q || drain) begin
      head_v_d = accept;
      if (accept) head_d = in_e;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
    end
  end
`endif

  // Head drives the MEM side; control bits never assert on a bubble
  assign out_valid    = head_v_q;
  assign pc_out       = head_q.pc;
  assign alu_res_out  = head_q.alu_res;
  assign val_rm_out   = head_q.val_rm;
  assign dest_out     = head_q.dest;
  assign mem_w_en_out = head_q.mem_w_en & head_v_q;
  assign mem_r_en_out = head_q.mem_r_en & head_v_q;
  assign wb_en_out    = head_q.wb_en & head_v_q;

endmodule

// File: tb/tb_exe_mem_elastic_reg.sv
// Scoreboard bench for exe_mem_elastic_reg: accepted bundles are queued,
// a monitor pops and compares every drained bundle.
module tb_exe_mem_elastic_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc_in = '0, alu_res_in = '0, val_rm_in = '0;
  logic [3:0]  dest_in = '0;
  logic        mem_w_en_in = 1'b0, mem_r_en_in = 1'b0, wb_en_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out, alu_res_out, val_rm_out;
  logic [3:0]  dest_out;
  logic        mem_w_en_out, mem_r_en_out, wb_en_out;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        mw;
    logic        mr;
    logic        wb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exe_mem_elastic_reg #(.ADDR_W(32), .DEST_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .mem_w_en_in(mem_w_en_in), .mem_r_en_in(mem_r_en_in),
    .wb_en_in(wb_en_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .mem_w_en_out(mem_w_en_out),
    .mem_r_en_out(mem_r_en_out), .wb_en_out(wb_en_out),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rm, input logic [3:0] d,
                        input logic mw, input logic mr, input logic wb);
    in_valid    = v;
    pc_in       = pc;
    alu_res_in  = alu;
    val_rm_in   = rm;
    dest_in     = d;
    mem_w_en_in = mw;
    mem_r_en_in = mr;
    wb_en_in    = wb;
  endtask

  // One clock: record an accepted bundle, then return #1 after the edge
  task automatic cyc();
    @(negedge clk);
    if (in_valid && in_ready && !flush && !rst)
      exp_q.push_back('{pc_in, alu_res_in, val_rm_in, dest_in,
                        mem_w_en_in, mem_r_en_in, wb_en_in});
    @(posedge clk);
    #1;
  endtask

  // Compare every drained bundle and check bubbles carry no enables
  task automatic monitor();
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          a = '{pc_out, alu_res_out, val_rm_out, dest_out,
                mem_w_en_out, mem_r_en_out, wb_en_out};
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL mon_unexpected: got bundle alu=%0h expected none", a.alu);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              n_bad++;
              $display("FAIL mon_bundle: got %h expected %h", a, e);
            end
          end
        end else if (!out_valid) begin
          chk("bubble_ctrl", 64'({mem_w_en_out, mem_r_en_out, wb_en_out}), 64'd0);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu", 64'(alu_res_out), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'd0);
    chk("rst_wb", 64'(wb_en_out), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single bundle
    out_ready = 1'b1;
    set_in(1'b1, 32'h10, 32'hDEADBEEF, 32'h55, 4'h3, 1'b0, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_alu", 64'(alu_res_out), 64'hDEADBEEF);
    chk("single_dest", 64'(dest_out), 64'd3);
    chk("single_wb", 64'(wb_en_out), 64'd1);
    cyc();
    chk("single_after_valid", 64'(out_valid), 64'd0);
    chk("single_after_wb", 64'(wb_en_out), 64'd0);

    // Stream of 8 at full throughput
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 32'h100 + 32'(i * 4), 32'(i), 32'(i) << 8, 4'(i),
             1'(i & 1), 1'((i >> 1) & 1), 1'b1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      cyc();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_alu", 64'(alu_res_out), 64'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

`ifdef EXE_MEM_REG_SKID_EN
    // Fill head and skid, hold C upstream, then drain A, B, C
    out_ready = 1'b0;
    set_in(1'b1, 32'h200, 32'hA, 32'h1, 4'h1, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("skid_occ1", 64'(occupancy), 64'd1);
    set_in(1'b1, 32'h204, 32'hB, 32'h2, 4'h2, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("skid_occ2", 64'(occupancy), 64'd2);
    chk("skid_full_ready", 64'(in_ready), 64'd0);
    chk("skid_head_a", 64'(alu_res_out), 64'hA);
    set_in(1'b1, 32'h208, 32'hC, 32'h3, 4'h5, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("skid_hold_occ", 64'(occupancy), 64'd2);
    chk("skid_hold_a", 64'(alu_res_out), 64'hA);
    out_ready = 1'b1;
    cyc();
    chk("skid_out_b", 64'(alu_res_out), 64'hB);
    chk("skid_occ_drop", 64'(occupancy), 64'd1);
    chk("skid_ready_rise", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("skid_out_c", 64'(alu_res_out), 64'hC);
    chk("skid_occ_c", 64'(occupancy), 64'd1);
    cyc();
    chk("skid_empty", 64'(out_valid), 64'd0);
`else
    // Held bundle blocks input until out_ready rises, then swap in one cycle
    out_ready = 1'b0;
    set_in(1'b1, 32'h300, 32'h77, 32'h7, 4'h7, 1'b1, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk("ns_held_ready", 64'(in_ready), 64'd0);
    chk("ns_held_occ", 64'(occupancy), 64'd1);
    set_in(1'b1, 32'h304, 32'h88, 32'h8, 4'h8, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("ns_comb_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("ns_swap_alu", 64'(alu_res_out), 64'h88);
    chk("ns_swap_occ", 64'(occupancy), 64'd1);
    cyc();
    chk("ns_empty", 64'(out_valid), 64'd0);
`endif

    // Flush a full register while a new input is offered
    out_ready = 1'b0;
    set_in(1'b1, 32'h400, 32'h41, 32'h0, 4'h9, 1'b1, 1'b0, 1'b0);
    cyc();
`ifdef EXE_MEM_REG_SKID_EN
    set_in(1'b1, 32'h404, 32'h42, 32'h0, 4'hA, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
`else
    chk("flush_pre_occ", 64'(occupancy), 64'd1);
`endif
    set_in(1'b1, 32'h408, 32'h43, 32'h0, 4'hB, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    exp_q.delete();
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_mw", 64'(mem_w_en_out), 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_no_emit", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with a bundle held
    out_ready = 1'b0;
    set_in(1'b1, 32'h500, 32'h5A5A, 32'h1234, 4'hC, 1'b0, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("arst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_alu", 64'(alu_res_out), 64'd0);
    chk("arst_pc", 64'(pc_out), 64'd0);
    chk("arst_rm", 64'(val_rm_out), 64'd0);
    chk("arst_ctrl", 64'({mem_w_en_out, mem_r_en_out, wb_en_out}), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_release_ready", 64'(in_ready), 64'd1);
    chk("arst_release_valid", 64'(out_valid), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
